// File: rtl/spi_port_pkg.sv
// Shared definitions for the SPI port: register addresses, STATUS bit
// positions, engine state encoding and a STATUS word builder.
package spi_port_pkg;

    // Word addresses (CPU addr[3:1])
    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_CS     = 3'd3;

    // STATUS bit positions
    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_BUSY     = 4;
    localparam int ST_TXOV     = 5;
    localparam int ST_RXOV     = 6;

    // Engine states
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_STORE = 2'd3;

    // Assemble the STATUS read word; unused bits read as zero.
    function automatic logic [15:0] pack_status(
        input logic tx_full,
        input logic tx_empty,
        input logic rx_full,
        input logic rx_empty,
        input logic busy,
        input logic txov,
        input logic rxov
    );
        logic [15:0] s;
        s              = 16'h0000;
        s[ST_TX_FULL]  = tx_full;
        s[ST_TX_EMPTY] = tx_empty;
        s[ST_RX_FULL]  = rx_full;
        s[ST_RX_EMPTY] = rx_empty;
        s[ST_BUSY]     = busy;
        s[ST_TXOV]     = txov;
        s[ST_RXOV]     = rxov;
        return s;
    endfunction

endpackage

// File: rtl/spi_fifo.sv
// 8-bit synchronous FIFO. A push while full is accepted only when a pop
// happens in the same cycle (the pop frees the slot); otherwise it is dropped.
module spi_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_head    = r_mem[r_rptr];

    // Storage array write port; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power of two).
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_port.sv
// CPU-bus SPI master port (mode 0, MSB first) with TX/RX byte FIFOs,
// software chip select and level interrupt on RX data available.
module spi_port
    import spi_port_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] RESET_DIV  = 8'd3
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        sel,
    input  logic [2:0]  addr,
    input  logic        r,
    input  logic [1:0]  w,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        irq,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);

    // Bus strobe edge detectors
    logic        r_rd_q;
    logic        r_wr_q;
    logic        w_rd_acc;
    logic        w_wr_acc;

    // Control / status registers
    logic [7:0]  r_div;
    logic        r_ie;
    logic        r_cs_n;
    logic        r_txov;
    logic        r_rxov;

    // Engine
    logic [1:0]  r_state;
    logic [7:0]  r_shreg;
    logic        r_samp;
    logic [2:0]  r_bit;
    logic [7:0]  r_cnt;
    logic        r_sck;
    logic        r_mosi;

    // FIFO hookup
    logic        w_tx_push;
    logic        w_tx_pop;
    logic [7:0]  w_tx_head;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic        w_rx_push;
    logic        w_rx_pop;
    logic [7:0]  w_rx_head;
    logic        w_rx_full;
    logic        w_rx_empty;

    logic        w_busy;
    logic        w_status_clr;
    logic [15:0] w_rdata;
    logic        w_unused_din;

    assign w_unused_din = ^din[15:9];

    // One access per strobe assertion, however long the CPU holds it.
    assign w_rd_acc = sel & r & ~r_rd_q;
    assign w_wr_acc = sel & (|w) & ~r_wr_q;

    assign w_tx_push    = w_wr_acc & (addr == ADDR_DATA) & w[0];
    assign w_tx_pop     = (r_state == S_LOAD);
    assign w_rx_push    = (r_state == S_STORE);
    assign w_rx_pop     = w_rd_acc & (addr == ADDR_DATA);
    assign w_status_clr = w_wr_acc & (addr == ADDR_STATUS) & w[0];

    assign w_busy   = (r_state != S_IDLE) | ~w_tx_empty;
    assign irq      = r_ie & ~w_rx_empty;
    assign spi_sck  = r_sck;
    assign spi_mosi = r_mosi;
    assign spi_cs_n = r_cs_n;
    assign dout     = (sel & r) ? w_rdata : 16'h0000;

    spi_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .nreset  (nreset),
        .i_push  (w_tx_push),
        .i_din   (din[7:0]),
        .i_pop   (w_tx_pop),
        .o_head  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    spi_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .nreset  (nreset),
        .i_push  (w_rx_push),
        .i_din   (r_shreg),
        .i_pop   (w_rx_pop),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    // Remember last-cycle strobe levels for rising-edge access detection.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rd_q <= 1'b0;
            r_wr_q <= 1'b0;
        end else begin
            r_rd_q <= sel & r;
            r_wr_q <= sel & (|w);
        end
    end

    // CTRL and CS registers, byte-lane write enables.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_div  <= RESET_DIV;
            r_ie   <= 1'b0;
            r_cs_n <= 1'b1;
        end else if (w_wr_acc) begin
            if (addr == ADDR_CTRL && w[0]) begin
                r_div <= din[7:0];
            end
            if (addr == ADDR_CTRL && w[1]) begin
                r_ie <= din[8];
            end
            if (addr == ADDR_CS && w[0]) begin
                r_cs_n <= din[0];
            end
        end
    end

    // Sticky overflow flags; a new overflow wins over a same-cycle clear.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_txov <= 1'b0;
            r_rxov <= 1'b0;
        end else begin
            if (w_tx_push && w_tx_full && !w_tx_pop) begin
                r_txov <= 1'b1;
            end else if (w_status_clr && din[ST_TXOV]) begin
                r_txov <= 1'b0;
            end
            if (w_rx_push && w_rx_full && !(w_rx_pop && !w_rx_empty)) begin
                r_rxov <= 1'b1;
            end else if (w_status_clr && din[ST_RXOV]) begin
                r_rxov <= 1'b0;
            end
        end
    end

    // Shift engine: half-period counter compares against live div so a
    // change lands at the next boundary; sample on rise, shift on fall.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
            r_shreg <= 8'h00;
            r_samp  <= 1'b0;
            r_bit   <= 3'd0;
            r_cnt   <= 8'd0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_sck  <= 1'b0;
                    r_mosi <= 1'b0;
                    if (!w_tx_empty) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_shreg <= w_tx_head;
                    r_mosi  <= w_tx_head[7];
                    r_cnt   <= 8'd0;
                    r_bit   <= 3'd0;
                    r_sck   <= 1'b0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_cnt >= r_div) begin
                        r_cnt <= 8'd0;
                        if (!r_sck) begin
                            r_sck  <= 1'b1;
                            r_samp <= spi_miso;
                        end else begin
                            r_sck   <= 1'b0;
                            r_shreg <= {r_shreg[6:0], r_samp};
                            r_mosi  <= r_shreg[6];
                            if (r_bit == 3'd7) begin
                                r_state <= S_STORE;
                            end else begin
                                r_bit <= r_bit + 3'd1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_STORE: begin
                    r_state <= w_tx_empty ? S_IDLE : S_LOAD;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Register read multiplexer; unmapped addresses read zero.
    always_comb begin
        w_rdata = 16'h0000;
        case (addr)
            ADDR_DATA:   w_rdata = w_rx_empty ? 16'h0000 : {8'h00, w_rx_head};
            ADDR_STATUS: w_rdata = pack_status(w_tx_full, w_tx_empty, w_rx_full,
                                               w_rx_empty, w_busy, r_txov, r_rxov);
            ADDR_CTRL:   w_rdata = {7'b0000000, r_ie, r_div};
            ADDR_CS:     w_rdata = {15'h0000, r_cs_n};
            default:     w_rdata = 16'h0000;
        endcase
    end

endmodule
